i2s_clk_gen: RTL and testbench
==============================

Name: i2s_clk_gen

Overview:
- Parametrised successor to the fixed-ratio audio clock divider.
- Generates a bit clock (BCLK) and a word-select clock (LRCLK) from the 50 MHz codec master clock.
- The BCLK ratio is programmable at run time, and the slot width is set by parameter.
- Start and stop are clean: the block only stops on a frame boundary.
- It also emits single-cycle edge strobes and a bit index, so I2S serialisers in the same clock domain sample without an extra clock.

Parameters:
DIV_W, 8, width of div_half input and prescaler counter
SLOT_BITS, 32, BCLK periods per channel slot (LRCLK half-period); must be >= 2
IDX_W, 5, width of bit_idx; must be >= clog2(SLOT_BITS)

Ports:
clk_in  input  1  master clock (50 MHz); single clock domain
rst  input  1  asynchronous, active-high reset
en  input  1  run request; level-sensitive
div_half  input  DIV_W  BCLK half-period in clk_in cycles; 0 is treated as 1
bclk_out  output  1  bit clock, idles low
lrclk_out  output  1  word select; 0 = left, 1 = right; idles low
bclk_rise  output  1  one-cycle strobe in the first cycle bclk_out reads 1
bclk_fall  output  1  one-cycle strobe in the first cycle bclk_out reads 0
frame_start  output  1  one-cycle strobe coincident with the bclk_fall that starts a left slot
bit_idx  output  IDX_W  bit position in the current slot, 0..SLOT_BITS-1
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, immediate, any state): state=IDLE; every output 0; prescaler, bit counter and shadow divider cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Shadow divider:
- div_sh <= max(div_half,1).
- Loaded on the IDLE->RUN transition and in every cycle where frame_start is asserted.
- div_half changes at any other time have no effect until the next frame boundary.

Prescaler:
- pcnt counts 0..div_sh-1 in RUN/DRAIN.
- At pcnt==div_sh-1: pcnt<=0 and bclk_out toggles.
- BCLK period = 2*div_sh clk_in cycles, 50% duty.
- Strobes are registered alongside the toggle: bclk_rise or bclk_fall is high exactly in the first cycle the new level is visible.

Bit counter / LRCLK (updated only on falling BCLK edges):
- If bit_idx==SLOT_BITS-1: bit_idx<=0 and lrclk_out toggles.
- Else: bit_idx<=bit_idx+1.
- frame_start=1 on the falling edge where lrclk_out goes 1->0, but only in RUN.
- The first slot after IDLE is left, with lrclk_out=0 and bit_idx=0; no frame_start is pulsed for this first slot.

FSM:
- IDLE: bclk_out=0, lrclk_out=0, pcnt=0, bit_idx=0.
  - en=1 sampled in cycle t: state=RUN at t+1, pcnt starts at 0.
  - First bclk_rise occurs in cycle t+1+div_sh.
- RUN:
  - en=0 -> DRAIN on the next cycle.
  - Clocks continue uninterrupted.
- DRAIN:
  - Clocks continue until the falling edge where lrclk_out would go 1->0 (end of the right slot).
  - On that edge: bclk_out=0, lrclk_out=0, bit_idx=0, frame_start NOT asserted, state=IDLE.
  - en=1 during DRAIN -> back to RUN with no glitch, phase reset or counter change.
  - en=0 while in a left slot: DRAIN lasts through the remainder of the left slot plus the whole right slot.
- busy=1 iff state is RUN or DRAIN.

Boundary conditions:
- div_half=0 behaves exactly as div_half=1 (BCLK = clk_in/2).
- Max div_half = 2^DIV_W-1, with no wrap in pcnt.
- bit_idx wraps only at SLOT_BITS-1.
- With SLOT_BITS=32, DIV_W=8 and div_half=1, LRCLK = clk_in/128.

Test Plan:
1. Reset and idle: assert rst mid-RUN -> all outputs 0 in the same cycle; after release with en=0, outputs stay 0 for 100 cycles.
2. Start latency (SLOT_BITS=4, div_half=2): en rises, sampled in cycle t -> bclk_rise at t+3; BCLK period 4 cycles; lrclk_out rises at bclk_fall #4 (cycle t+17); frame_start at bclk_fall #8; LRCLK period 32 cycles; bit_idx sequence 0,1,2,3,0.
3. Divider shadowing: change div_half 2->5 mid-slot -> BCLK period stays 4 until the cycle after frame_start, then becomes 10; div_half=0 -> period 2.
4. Drain: drop en during left slot bit 1 -> clocks continue through bit 3 of the right slot, then bclk_out=0, lrclk_out=0, busy=0, and no frame_start on the final edge.
5. Re-enable in DRAIN: raise en two BCLK periods after dropping it -> busy never falls; edge spacing is unchanged; the next frame_start arrives on schedule.
6. Default check (SLOT_BITS=32, div_half=1): LRCLK period 128 clk_in cycles; exactly 64 bclk_rise strobes per frame.

Source files
------------

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module   : i2s_clk_gen
// Purpose  : I2S BCLK/LRCLK generator with run-time BCLK divider, frame-aligned
//            start/stop, edge strobes and slot bit index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clk_gen #(
    parameter int DIV_W     = 8,
    parameter int SLOT_BITS = 32,
    parameter int IDX_W     = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_half,
    output logic             bclk_out,
    output logic             lrclk_out,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             frame_start,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_DRAIN    = 2'd2;
    localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(SLOT_BITS - 1);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] r_div_sh;
    logic             r_bclk;
    logic             r_lrclk;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_rise;
    logic             r_fall;
    logic             r_frame;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] w_pcnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_bclk_nxt;
    logic             w_lrclk_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_frame_nxt;
    logic             w_busy_nxt;

    logic [DIV_W-1:0] w_div_eff;
    logic             w_tick;
    logic             w_slot_end;
    logic             w_frame_edge;
    logic             w_stop;

    assign w_div_eff    = (div_half == '0) ? c_DIV_ONE : div_half;
    assign w_tick       = (r_pcnt == (r_div_sh - c_DIV_ONE));
    assign w_slot_end   = (r_bit_idx == c_IDX_LAST);
    // Falling BCLK edge that closes a right slot: the only legal frame boundary.
    assign w_frame_edge = w_tick && r_bclk && w_slot_end && r_lrclk;
    assign w_stop       = (r_state == c_DRAIN) && !en && w_frame_edge;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (en) w_state_nxt = c_RUN;
            c_RUN:   if (!en) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (w_stop) begin
                    w_state_nxt = c_IDLE;
                end else if (en) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_pcnt_nxt  = r_pcnt;
        w_div_nxt   = r_div_sh;
        w_bclk_nxt  = r_bclk;
        w_lrclk_nxt = r_lrclk;
        w_idx_nxt   = r_bit_idx;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_frame_nxt = 1'b0;
        w_busy_nxt  = (w_state_nxt != c_IDLE);
        if (r_state == c_IDLE) begin
            w_pcnt_nxt  = '0;
            w_bclk_nxt  = 1'b0;
            w_lrclk_nxt = 1'b0;
            w_idx_nxt   = '0;
            if (en) begin
                w_div_nxt = w_div_eff;
            end
        end else if (w_tick) begin
            w_pcnt_nxt = '0;
            w_bclk_nxt = !r_bclk;
            w_rise_nxt = !r_bclk;
            w_fall_nxt = r_bclk;
            if (r_bclk) begin
                // A stopping edge lands on lrclk=0, idx=0, bclk=0 naturally.
                if (w_slot_end) begin
                    w_idx_nxt   = '0;
                    w_lrclk_nxt = !r_lrclk;
                end else begin
                    w_idx_nxt = r_bit_idx + c_IDX_ONE;
                end
                if (w_frame_edge && !w_stop) begin
                    w_frame_nxt = 1'b1;
                    w_div_nxt   = w_div_eff;
                end
            end
        end else begin
            w_pcnt_nxt = r_pcnt + c_DIV_ONE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pcnt    <= '0;
            r_div_sh  <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_bit_idx <= '0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_frame   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pcnt    <= w_pcnt_nxt;
            r_div_sh  <= w_div_nxt;
            r_bclk    <= w_bclk_nxt;
            r_lrclk   <= w_lrclk_nxt;
            r_bit_idx <= w_idx_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_frame   <= w_frame_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bclk_out    = r_bclk;
    assign lrclk_out   = r_lrclk;
    assign bclk_rise   = r_rise;
    assign bclk_fall   = r_fall;
    assign frame_start = r_frame;
    assign bit_idx     = r_bit_idx;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2s_clk_gen.sv
// ============================================================================
// Module   : tb_i2s_clk_gen
// Purpose  : Scoreboard bench for i2s_clk_gen (SLOT_BITS=4 and default 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_clk_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en4, en32;
    logic [7:0] div4, div32;
    logic       bclk4, lr4, rise4, fall4, fs4, busy4;
    logic [4:0] idx4;
    logic       bclk32, lr32, rise32, fall32, fs32, busy32;
    logic [4:0] idx32;

    int cyc;
    int errors;
    int checks;
    int q_rise[$];
    int q_fall[$];
    int q_frame[$];
    int q_idx[$];
    int q_lr[$];

    always #5 clk = ~clk;

    i2s_clk_gen #(.DIV_W(8), .SLOT_BITS(4), .IDX_W(5)) dut4 (
        .clk_in(clk), .rst(rst), .en(en4), .div_half(div4),
        .bclk_out(bclk4), .lrclk_out(lr4), .bclk_rise(rise4), .bclk_fall(fall4),
        .frame_start(fs4), .bit_idx(idx4), .busy(busy4)
    );

    i2s_clk_gen dut32 (
        .clk_in(clk), .rst(rst), .en(en32), .div_half(div32),
        .bclk_out(bclk32), .lrclk_out(lr32), .bclk_rise(rise32), .bclk_fall(fall32),
        .frame_start(fs32), .bit_idx(idx32), .busy(busy32)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic restart();
        rst = 1'b1;
        en4 = 1'b0;
        en32 = 1'b0;
        step();
        rst = 1'b0;
        q_rise.delete();
        q_fall.delete();
        q_frame.delete();
        q_idx.delete();
        q_lr.delete();
        step();
    endtask

    task automatic test_reset();
        int bad;
        step();
        checks++;
        if ({bclk4, lr4, rise4, fall4, fs4, idx4, busy4} !== 11'd0) begin
            errors++;
            $display("FAIL reset_dut4: outputs %b expected all zero", {bclk4, lr4, rise4, fall4, fs4, idx4, busy4});
        end
        checks++;
        if ({bclk32, lr32, rise32, fall32, fs32, idx32, busy32} !== 11'd0) begin
            errors++;
            $display("FAIL reset_dut32: outputs %b expected all zero", {bclk32, lr32, rise32, fall32, fs32, idx32, busy32});
        end
        rst = 1'b0;
        div4 = 8'd2;
        en4 = 1'b1;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun_busy: got %b expected 1", busy4);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bclk4, lr4, rise4, fall4, fs4, idx4, busy4} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: outputs %b expected all zero", {bclk4, lr4, rise4, fall4, fs4, idx4, busy4});
        end
        en4 = 1'b0;
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({bclk4, lr4, rise4, fall4, fs4, idx4, busy4} !== 11'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_start();
        int t, e, ei, el;
        restart();
        div4 = 8'd2;
        en4 = 1'b1;
        t = cyc;
        for (int n = 1; n <= 17; n++) begin
            q_rise.push_back(t - 1 + 4 * n);
            q_fall.push_back(t + 1 + 4 * n);
            q_idx.push_back(n % 4);
            q_lr.push_back((n / 4) % 2);
            if (n % 8 == 0) q_frame.push_back(t + 1 + 4 * n);
        end
        for (int c = t + 1; c <= t + 70; c++) begin
            step();
            if (rise4) begin
                checks++;
                e = (q_rise.size() != 0) ? q_rise.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL start_rise: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
            if (fall4) begin
                checks++;
                e  = (q_fall.size() != 0) ? q_fall.pop_front() : -1;
                ei = (q_idx.size() != 0) ? q_idx.pop_front() : -1;
                el = (q_lr.size() != 0) ? q_lr.pop_front() : -1;
                if (cyc !== e || int'(idx4) !== ei || int'(lr4) !== el) begin
                    errors++;
                    $display("FAIL start_fall: got t+%0d idx=%0d lr=%0d expected t+%0d idx=%0d lr=%0d",
                             cyc - t, idx4, lr4, e - t, ei, el);
                end
            end
            if (fs4) begin
                checks++;
                e = (q_frame.size() != 0) ? q_frame.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL start_frame: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
        end
        checks++;
        if (q_rise.size() + q_fall.size() + q_frame.size() != 0) begin
            errors++;
            $display("FAIL start_missing: %0d events left expected 0", q_rise.size() + q_fall.size() + q_frame.size());
        end
    endtask

    task automatic test_shadow();
        int t, e, f1, f2;
        restart();
        div4 = 8'd2;
        en4 = 1'b1;
        t = cyc;
        f1 = t + 33;
        f2 = f1 + 80;
        for (int n = 1; n <= 8; n++) begin
            q_rise.push_back(t - 1 + 4 * n);
            q_fall.push_back(t + 1 + 4 * n);
        end
        for (int n = 1; n <= 8; n++) begin
            q_rise.push_back(f1 - 5 + 10 * n);
            q_fall.push_back(f1 + 10 * n);
        end
        for (int n = 1; n <= 6; n++) begin
            q_rise.push_back(f2 - 1 + 2 * n);
            q_fall.push_back(f2 + 2 * n);
        end
        q_frame.push_back(f1);
        q_frame.push_back(f2);
        for (int c = t + 1; c <= f2 + 12; c++) begin
            step();
            if (cyc == t + 20) div4 = 8'd5;
            if (cyc == f1 + 30) div4 = 8'd0;
            if (rise4) begin
                checks++;
                e = (q_rise.size() != 0) ? q_rise.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL shadow_rise: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
            if (fall4) begin
                checks++;
                e = (q_fall.size() != 0) ? q_fall.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL shadow_fall: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
            if (fs4) begin
                checks++;
                e = (q_frame.size() != 0) ? q_frame.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL shadow_frame: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
        end
        checks++;
        if (q_rise.size() + q_fall.size() + q_frame.size() != 0) begin
            errors++;
            $display("FAIL shadow_missing: %0d events left expected 0", q_rise.size() + q_fall.size() + q_frame.size());
        end
    endtask

    // i_reen < 0 leaves en low for the rest of the run.
    task automatic test_drain(input int i_reen, input string name);
        int t, e, bad_busy, last;
        restart();
        div4 = 8'd2;
        en4 = 1'b1;
        t = cyc;
        last = (i_reen < 0) ? 8 : 17;
        for (int n = 1; n <= last; n++) begin
            q_rise.push_back(t - 1 + 4 * n);
            q_fall.push_back(t + 1 + 4 * n);
            if (n % 8 == 0 && i_reen >= 0) q_frame.push_back(t + 1 + 4 * n);
        end
        bad_busy = 0;
        for (int c = t + 1; c <= t + 70; c++) begin
            step();
            if (cyc == t + 6) en4 = 1'b0;
            if (i_reen >= 0 && cyc == t + i_reen) en4 = 1'b1;
            if (busy4 !== ((i_reen >= 0) || (cyc <= t + 32))) bad_busy++;
            if (i_reen < 0 && cyc == t + 33) begin
                checks++;
                if ({bclk4, lr4, idx4, busy4, fs4} !== 9'd0) begin
                    errors++;
                    $display("FAIL %s_final: bclk/lr/idx/busy/fs %b expected all zero", name, {bclk4, lr4, idx4, busy4, fs4});
                end
            end
            if (rise4) begin
                checks++;
                e = (q_rise.size() != 0) ? q_rise.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL %s_rise: got cycle t+%0d expected t+%0d", name, cyc - t, e - t);
                end
            end
            if (fall4) begin
                checks++;
                e = (q_fall.size() != 0) ? q_fall.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL %s_fall: got cycle t+%0d expected t+%0d", name, cyc - t, e - t);
                end
            end
            if (fs4) begin
                checks++;
                e = (q_frame.size() != 0) ? q_frame.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL %s_frame: got cycle t+%0d expected t+%0d", name, cyc - t, e - t);
                end
            end
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL %s_busy: %0d wrong cycles expected 0", name, bad_busy);
        end
        checks++;
        if (q_rise.size() + q_fall.size() + q_frame.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d events left expected 0", name, q_rise.size() + q_fall.size() + q_frame.size());
        end
    endtask

    task automatic test_max_div();
        int t, nr, nf, fr, ff;
        restart();
        div4 = 8'd255;
        en4 = 1'b1;
        t = cyc;
        nr = 0;
        nf = 0;
        fr = -1;
        ff = -1;
        for (int c = t + 1; c <= t + 512; c++) begin
            step();
            if (rise4) begin
                nr++;
                if (fr < 0) fr = cyc;
            end
            if (fall4) begin
                nf++;
                if (ff < 0) ff = cyc;
            end
        end
        checks++;
        if (fr !== t + 256 || nr !== 1) begin
            errors++;
            $display("FAIL maxdiv_rise: first t+%0d count %0d expected t+256 count 1", fr - t, nr);
        end
        checks++;
        if (ff !== t + 511 || nf !== 1) begin
            errors++;
            $display("FAIL maxdiv_fall: first t+%0d count %0d expected t+511 count 1", ff - t, nf);
        end
    endtask

    task automatic test_default();
        int t, e, ei, el, nrise;
        restart();
        div32 = 8'd1;
        en32 = 1'b1;
        t = cyc;
        for (int n = 1; n <= 130; n++) q_rise.push_back(t + 2 * n);
        for (int n = 1; n <= 129; n++) begin
            q_fall.push_back(t + 1 + 2 * n);
            q_idx.push_back(n % 32);
            q_lr.push_back((n / 32) % 2);
            if (n % 64 == 0) q_frame.push_back(t + 1 + 2 * n);
        end
        nrise = 0;
        for (int c = t + 1; c <= t + 260; c++) begin
            step();
            if (rise32 && cyc >= t + 129 && cyc < t + 257) nrise++;
            if (rise32) begin
                checks++;
                e = (q_rise.size() != 0) ? q_rise.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL default_rise: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
            if (fall32) begin
                checks++;
                e  = (q_fall.size() != 0) ? q_fall.pop_front() : -1;
                ei = (q_idx.size() != 0) ? q_idx.pop_front() : -1;
                el = (q_lr.size() != 0) ? q_lr.pop_front() : -1;
                if (cyc !== e || int'(idx32) !== ei || int'(lr32) !== el) begin
                    errors++;
                    $display("FAIL default_fall: got t+%0d idx=%0d lr=%0d expected t+%0d idx=%0d lr=%0d",
                             cyc - t, idx32, lr32, e - t, ei, el);
                end
            end
            if (fs32) begin
                checks++;
                e = (q_frame.size() != 0) ? q_frame.pop_front() : -1;
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL default_frame: got cycle t+%0d expected t+%0d", cyc - t, e - t);
                end
            end
        end
        checks++;
        if (nrise != 64) begin
            errors++;
            $display("FAIL default_rises_per_frame: got %0d expected 64", nrise);
        end
        checks++;
        if (q_rise.size() + q_fall.size() + q_frame.size() != 0) begin
            errors++;
            $display("FAIL default_missing: %0d events left expected 0", q_rise.size() + q_fall.size() + q_frame.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        en4 = 1'b0;
        en32 = 1'b0;
        div4 = 8'd0;
        div32 = 8'd0;
        cyc = 0;
        errors = 0;
        checks = 0;
        test_reset();
        test_start();
        test_shadow();
        test_drain(-1, "drain");
        test_drain(14, "reenable");
        test_max_div();
        test_default();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
